// File: rtl/rtc_bus_arbiter.sv
// RTC bus arbiter: interleaves host register writes with periodic time-refresh scans.
// Define RTC_TIMEOUT_EN to build in the WAIT watchdog.
module rtc_bus_arbiter #(
  parameter int unsigned SCAN_PERIOD = 50000,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       txn_start,
  input  logic       txn_done,
  output logic [7:0] dir_out,
  output logic [7:0] dato,
  output logic       RD_WR,
  input  logic [7:0] dato_rtc,
  output logic [7:0] rd_data,
  output logic [2:0] rd_idx,
  output logic       rd_valid,
  output logic       busy,
  output logic       err_timeout
);

  localparam int SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [SCAN_W-1:0] SCAN_RELOAD = SCAN_W'(SCAN_PERIOD - 1);
  localparam logic [2:0] LAST_IDX  = 3'd5;
  localparam logic [7:0] SCAN_BASE = 8'h21;

  // state   | meaning
  // S_IDLE  | bus free, arbitration happens here
  // S_START | one-cycle launch, txn_start high
  // S_WAIT  | waiting for txn_done from the bus driver
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t            r_state;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic              r_scan_pend;
  logic              r_ptr_wr;
  logic              r_wr_block;
  logic [2:0]        r_idx;

  logic       w_scan_exp;
  logic       w_wr_elig;
  logic       w_grant_wr;
  logic       w_grant_rd;
  logic       w_abort;
  logic       w_finish;
  logic [7:0] w_rd_byte;

  assign w_scan_exp = (r_scan_cnt == '0);
  assign w_wr_elig  = wr_req & ~r_wr_block;
  assign w_grant_wr = w_wr_elig & (~r_scan_pend | r_ptr_wr);
  assign w_grant_rd = r_scan_pend & ~w_grant_wr;
  assign w_finish   = txn_done | w_abort;
  assign w_rd_byte  = w_abort ? 8'hFF : dato_rtc;

`ifdef RTC_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign w_abort     = (r_state == S_WAIT) & ~txn_done & (r_to_cnt == '0);
  assign err_timeout = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (r_state == S_START) begin
        r_to_cnt <= TO_W'(TIMEOUT);
      end else if (r_state == S_WAIT && r_to_cnt != '0) begin
        r_to_cnt <= r_to_cnt - 1'b1;
      end
    end
  end
`else
  assign w_abort     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_scan_cnt  <= SCAN_RELOAD;
      r_scan_pend <= 1'b0;
      r_ptr_wr    <= 1'b1;
      r_wr_block  <= 1'b0;
      r_idx       <= 3'd0;
      txn_start   <= 1'b0;
      busy        <= 1'b0;
      dir_out     <= 8'h00;
      dato        <= 8'h00;
      RD_WR       <= 1'b1;
      rd_data     <= 8'h00;
      rd_idx      <= 3'd0;
      rd_valid    <= 1'b0;
      wr_ack      <= 1'b0;
    end else begin
      txn_start <= 1'b0;
      rd_valid  <= 1'b0;
      wr_ack    <= 1'b0;

      r_scan_cnt <= w_scan_exp ? SCAN_RELOAD : r_scan_cnt - 1'b1;
      // an expiry while a scan is still pending is simply lost
      if (w_scan_exp && !r_scan_pend) r_scan_pend <= 1'b1;
      if (!wr_req) r_wr_block <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_grant_wr) begin
            r_state   <= S_START;
            txn_start <= 1'b1;
            busy      <= 1'b1;
            dir_out   <= wr_addr;
            dato      <= wr_data;
            RD_WR     <= 1'b0;
            r_ptr_wr  <= 1'b0;
          end else if (w_grant_rd) begin
            r_state   <= S_START;
            txn_start <= 1'b1;
            busy      <= 1'b1;
            dir_out   <= SCAN_BASE + {5'd0, r_idx};
            dato      <= 8'h00;
            RD_WR     <= 1'b1;
            r_ptr_wr  <= 1'b1;
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_finish) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            if (RD_WR) begin
              rd_data  <= w_rd_byte;
              rd_idx   <= r_idx;
              rd_valid <= 1'b1;
              if (r_idx == LAST_IDX) begin
                r_idx       <= 3'd0;
                r_scan_pend <= 1'b0;
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end else begin
              wr_ack     <= 1'b1;
              // a requester still holding wr_req must drop it before the next grant
              r_wr_block <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter with a bus-driver responder and scoreboards.
module tb_rtc_bus_arbiter;
  localparam int SCAN_P = 100;
  localparam int TO     = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       txn_done = 1'b0;
  logic [7:0] dato_rtc = 8'h00;
  logic       wr_ack, txn_start, RD_WR, rd_valid, busy, err_timeout;
  logic [7:0] dir_out, dato, rd_data;
  logic [2:0] rd_idx;

  rtc_bus_arbiter #(.SCAN_PERIOD(SCAN_P), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .txn_start(txn_start), .txn_done(txn_done), .dir_out(dir_out),
    .dato(dato), .RD_WR(RD_WR), .dato_rtc(dato_rtc), .rd_data(rd_data), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [2:0] idx; logic [7:0] data;} rd_exp_t;

  int          checks = 0;
  int          errors = 0;
  rd_exp_t     exp_rd[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  seq[$];
  int          rd_cnt = 0;
  int          ack_cnt = 0;
  int          err_cnt = 0;
  logic [2:0]  model_idx = 3'd0;

  int         wr_go = 0;
  logic [7:0] go_addr = 8'h00;
  logic [7:0] go_data = 8'h00;
  int         hold_n = 0;
  bit         withhold = 1'b0;
  bit         early = 1'b0;
  bit         to_mode = 1'b0;
  int         idle_done_go = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // write requester and completion monitor
  initial begin : drv_mon
    int         served;
    int         holds;
    bit         reassert;
    logic [7:0] na, nd;
    rd_exp_t    e;
    served = 0; holds = 0; reassert = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        rd_cnt++;
        chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          chk("rd_idx", 32'(rd_idx), 32'(e.idx));
          chk("rd_data", 32'(rd_data), 32'(e.data));
        end
      end
      if (err_timeout) err_cnt++;
      if (!reset) begin
        wr_req = 1'b0; reassert = 1'b0; served = wr_go;
      end else if (wr_ack) begin
        ack_cnt++;
        wr_req = 1'b0;
        if (holds < hold_n) reassert = 1'b1;
      end else if (reassert) begin
        reassert = 1'b0; holds++;
        na = wr_addr + 8'h01; nd = wr_data + 8'h11;
        wr_addr = na; wr_data = nd; wr_req = 1'b1;
        exp_wr.push_back({na, nd});
      end else if (served != wr_go) begin
        served = wr_go;
        na = go_addr; nd = go_data;
        wr_addr = na; wr_data = nd; wr_req = 1'b1;
        exp_wr.push_back({na, nd});
      end
    end
  end

  // bus driver: answers each txn_start with txn_done three cycles later
  initial begin : responder
    bit          cap_rw, hang;
    logic [7:0]  cap_a, cap_d, rdat;
    logic [15:0] w;
    int          idle_served;
    idle_served = 0; rdat = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        model_idx = 3'd0;
      end else if (txn_start) begin
        cap_rw = RD_WR; cap_a = dir_out; cap_d = dato; hang = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        if (cap_rw) begin
          chk("rd_addr", 32'(dir_out), 32'(8'h21 + {5'd0, model_idx}));
          chk("rd_dato", 32'(dato), 32'd0);
          seq.push_back({5'd0, model_idx});
          hang = to_mode && (model_idx == 3'd4);
          rdat = 8'h10 + {5'd0, model_idx};
          exp_rd.push_back({model_idx, hang ? 8'hFF : rdat});
          model_idx = (model_idx == 3'd5) ? 3'd0 : model_idx + 3'd1;
        end else begin
          chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(dir_out), 32'(w[15:8]));
            chk("wr_dato", 32'(dato), 32'(w[7:0]));
          end
          seq.push_back(8'hA0);
          hang = withhold;
        end
        if (!hang) begin
          if (early && !cap_rw) begin
            txn_done = 1'b1;
            @(negedge clk);
            txn_done = 1'b0;
            chk("early_done_busy", 32'(busy), 32'd1);
            chk("early_done_ack", 32'(wr_ack), 32'd0);
            repeat (2) @(negedge clk);
          end else begin
            repeat (3) @(negedge clk);
          end
          txn_done = 1'b1; dato_rtc = rdat;
          chk("hold_addr", 32'(dir_out), 32'(cap_a));
          chk("hold_rw", 32'(RD_WR), 32'(cap_rw));
          chk("hold_dato", 32'(dato), 32'(cap_d));
          @(negedge clk);
          txn_done = 1'b0;
          chk("done_wr_ack", 32'(wr_ack), 32'(!cap_rw));
          chk("done_rd_valid", 32'(rd_valid), 32'(cap_rw));
          chk("done_busy", 32'(busy), 32'd0);
        end
      end else if (idle_served != idle_done_go) begin
        idle_served = idle_done_go;
        txn_done = 1'b1; dato_rtc = 8'h99;
        @(negedge clk);
        txn_done = 1'b0;
      end
    end
  end

  initial begin : main
    int         n, base, a0, r0;
    logic [7:0] e37[7];
    logic [7:0] e38[11];
    logic [7:0] e40[6];
    e37 = '{8'h00, 8'h01, 8'h02, 8'hA0, 8'h03, 8'h04, 8'h05};
    e38 = '{8'h00, 8'hA0, 8'h01, 8'hA0, 8'h02, 8'hA0, 8'h03, 8'hA0, 8'h04, 8'hA0, 8'h05};
    e40 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    step(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txn_start", 32'(txn_start), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_rd_wr", 32'(RD_WR), 32'd1);
    chk("rst_dir_out", 32'(dir_out), 32'd0);
    chk("rst_dato", 32'(dato), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_idx", 32'(rd_idx), 32'd0);

    // first scan after reset release
    reset = 1'b1;
    n = 0;
    while (!txn_start && n < 300) begin step(); n++; end
    chk("first_scan_delay", 32'(n), 32'(SCAN_P + 1));
    n = 0;
    while (rd_cnt < 6 && n < 100) begin step(); n++; end
    chk("scan1_reads", 32'(rd_cnt), 32'd6);
    step(3);

    // single write while idle
    go_addr = 8'h22; go_data = 8'h45; a0 = ack_cnt;
    wr_go++;
    n = 0;
    while (!wr_req && n < 5) begin step(); n++; end
    step();
    chk("wr_grant_latency", 32'(txn_start), 32'd1);
    chk("wr_rd_wr", 32'(RD_WR), 32'd0);
    chk("wr_dir_out", 32'(dir_out), 32'h22);
    chk("wr_dato_out", 32'(dato), 32'h45);
    n = 0;
    while (ack_cnt == a0 && n < 20) begin step(); n++; end
    chk("wr_ack_seen", 32'(ack_cnt), 32'(a0 + 1));
    step(4);

    // txn_done while idle is ignored
    a0 = ack_cnt; r0 = rd_cnt;
    idle_done_go++;
    step(2);
    chk("idle_done_busy", 32'(busy), 32'd0);
    step(3);
    chk("idle_done_no_ack", 32'(ack_cnt), 32'(a0));
    chk("idle_done_no_rd", 32'(rd_cnt), 32'(r0));

    // txn_done during START is ignored
    early = 1'b1; go_addr = 8'h30; go_data = 8'h5A;
    wr_go++;
    n = 0;
    while (ack_cnt == a0 && n < 20) begin step(); n++; end
    early = 1'b0;
    chk("early_wr_ack", 32'(ack_cnt), 32'(a0 + 1));

    // write requested during the idx 2 read
    base = seq.size();
    n = 0;
    while (!(txn_start && RD_WR && dir_out == 8'h23) && n < 200) begin step(); n++; end
    chk("idx2_found", 32'(n < 200), 32'd1);
    go_addr = 8'h40; go_data = 8'h77;
    wr_go++;
    n = 0;
    while (rd_cnt < 12 && n < 100) begin step(); n++; end
    step(3);
    chk("seq37_len", 32'(seq.size() - base), 32'd7);
    for (int i = 0; i < 7; i++)
      if (base + i < seq.size()) chk($sformatf("seq37_%0d", i), 32'(seq[base + i]), 32'(e37[i]));

    // write requester re-requesting throughout a scan
    step(5);
    base = seq.size(); a0 = ack_cnt; hold_n = 4;
    n = 0;
    while (!(txn_start && RD_WR && dir_out == 8'h21) && n < 200) begin step(); n++; end
    chk("idx0_found", 32'(n < 200), 32'd1);
    go_addr = 8'h50; go_data = 8'h01;
    wr_go++;
    n = 0;
    while (rd_cnt < 18 && n < 150) begin step(); n++; end
    step(3);
    chk("seq38_len", 32'(seq.size() - base), 32'd11);
    for (int i = 0; i < 11; i++)
      if (base + i < seq.size()) chk($sformatf("seq38_%0d", i), 32'(seq[base + i]), 32'(e38[i]));
    chk("seq38_acks", 32'(ack_cnt), 32'(a0 + 5));

    // reset in the middle of a write
    step(5);
    withhold = 1'b1; go_addr = 8'h60; go_data = 8'hC3; a0 = ack_cnt;
    wr_go++;
    n = 0;
    while (!txn_start && n < 10) begin step(); n++; end
    chk("rst_wr_started", 32'(RD_WR), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_wr", 32'(RD_WR), 32'd1);
    chk("midrst_dir_out", 32'(dir_out), 32'd0);
    chk("midrst_dato", 32'(dato), 32'd0);
    chk("midrst_txn_start", 32'(txn_start), 32'd0);
    step(2);
    withhold = 1'b0;
    reset = 1'b1;
    n = 0;
    while (!txn_start && n < 300) begin step(); n++; end
    chk("post_rst_scan_delay", 32'(n), 32'(SCAN_P + 1));
    n = 0;
    while (rd_cnt < 24 && n < 100) begin step(); n++; end
    chk("post_rst_reads", 32'(rd_cnt), 32'd24);
    chk("post_rst_no_ack", 32'(ack_cnt), 32'(a0));

`ifdef RTC_TIMEOUT_EN
    // watchdog abort on idx 4
    step(3);
    base = seq.size(); a0 = err_cnt; to_mode = 1'b1;
    n = 0;
    while (rd_cnt < 30 && n < 250) begin step(); n++; end
    to_mode = 1'b0;
    step(3);
    chk("to_err_pulse", 32'(err_cnt), 32'(a0 + 1));
    chk("to_seq_len", 32'(seq.size() - base), 32'd6);
    for (int i = 0; i < 6; i++)
      if (base + i < seq.size()) chk($sformatf("to_seq_%0d", i), 32'(seq[base + i]), 32'(e40[i]));
`else
    chk("no_err_timeout", 32'(err_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
